z80_fifo_uart: RTL and testbench

Parametrised successor to the single-channel polled serial port on the Z80 I/O bus. It runs entirely on `cpu_clk` and has four parts: an 8N1 UART, TX and RX FIFOs of configurable depth, a programmable I/O base address, and a level interrupt request for the fz80 `intreq` input. `data_out` is zero whenever the block is not being read, so it can be OR-merged onto the CPU read bus with ROM and RAM.

---
 rtl/z80_fifo_uart_if.sv | 13 +
 rtl/z80_fifo_uart.sv | 183 ++++++++++++++++++
 tb/tb_z80_fifo_uart.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/z80_fifo_uart_if.sv
// Z80 I/O bus view of the FIFO UART: CPU strobes, address, data and select.
interface z80_fifo_uart_if;
  logic [7:0] addr;
  logic       iorq;
  logic       rd;
  logic       wr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       sel;

  modport master (output addr, iorq, rd, wr, data_in, input data_out, sel);
  modport slave  (input addr, iorq, rd, wr, data_in, output data_out, sel);
endinterface

// File: rtl/z80_fifo_uart.sv
// 8N1 UART with TX/RX FIFOs on the Z80 I/O bus; data register at BASE_ADDR,
// status/control at BASE_ADDR+1, side effects on the trailing edge of an access.
module z80_fifo_uart #(
  parameter logic [7:0]  BASE_ADDR = 8'h84,
  parameter int unsigned FIFO_AW   = 4,
  parameter int unsigned BAUD_DIV  = 52
) (
  input  logic            n_RST,
  input  logic            cpu_clk,
  z80_fifo_uart_if.slave  bus,
  output logic            int_req,
  output logic            txd,
  input  logic            rxd
);
  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned PW    = FIFO_AW + 1;
  localparam int unsigned CW    = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_END  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic          rd_q, wr_q, reg_q;
  logic [7:0]    wdata;
  logic          rxie, txie, txovf, ovr, ferr;
  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [PW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  state_t        tx_state, rx_state;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic [2:0]    tx_bit, rx_bit;
  logic [7:0]    tx_sh, rx_sh;
  logic          rx_s1, rx_s2, rx_prev, rx_v1, rx_v2, rx_stop;

  // Bus decode and trailing-edge detection
  assign bus.sel = bus.iorq & (bus.addr[7:1] == BASE_ADDR[7:1]);
  wire rd_act     = bus.sel & bus.rd;
  wire wr_act     = bus.sel & bus.wr;
  wire rd_tr      = rd_q & ~rd_act;
  wire wr_tr      = wr_q & ~wr_act;
  wire data_rd_tr = rd_tr & ~reg_q;
  wire stat_rd_tr = rd_tr & reg_q;
  wire data_wr_tr = wr_tr & ~reg_q;
  wire ctrl_wr_tr = wr_tr & reg_q;
  wire tx_flush   = ctrl_wr_tr & wdata[3];
  wire rx_flush   = ctrl_wr_tr & wdata[2];

  wire tx_empty = (tx_wp == tx_rp);
  wire rx_empty = (rx_wp == rx_rp);
  wire tx_full  = (tx_wp[FIFO_AW] != tx_rp[FIFO_AW]) &&
                  (tx_wp[FIFO_AW-1:0] == tx_rp[FIFO_AW-1:0]);
  wire rx_full  = (rx_wp[FIFO_AW] != rx_rp[FIFO_AW]) &&
                  (rx_wp[FIFO_AW-1:0] == rx_rp[FIFO_AW-1:0]);
  wire [7:0] tx_head = tx_mem[tx_rp[FIFO_AW-1:0]];
  wire [7:0] rx_head = rx_mem[rx_rp[FIFO_AW-1:0]];

  // A flushed byte must not leak into the shifter
  wire tx_ready = ~tx_empty & ~tx_flush;
  wire tx_end   = (tx_cnt == BIT_END);
  wire tx_pop   = tx_ready & ((tx_state == S_IDLE) | ((tx_state == S_STOP) & tx_end));
  wire tx_push  = data_wr_tr & ~tx_full;
  wire rx_push  = rx_v2 & rx_stop & ~rx_full;
  wire rx_pop   = data_rd_tr & ~rx_empty;
  wire tx_idle  = tx_empty & (tx_state == S_IDLE);

  wire [7:0] status = {2'b00, txovf, tx_idle, ferr, ovr, ~tx_full, ~rx_empty};

  always_comb begin
    bus.data_out = 8'h00;
    if (rd_act) bus.data_out = bus.addr[0] ? status : (rx_empty ? 8'h00 : rx_head);
  end

  // Register interface, sticky flags and interrupt
  always_ff @(posedge cpu_clk or negedge n_RST) begin
    if (!n_RST) begin
      rd_q <= 1'b0; wr_q <= 1'b0; reg_q <= 1'b0; wdata <= 8'h00;
      rxie <= 1'b0; txie <= 1'b0; txovf <= 1'b0; ovr <= 1'b0; ferr <= 1'b0;
      int_req <= 1'b0;
    end else begin
      rd_q <= rd_act;
      wr_q <= wr_act;
      if (rd_act | wr_act) reg_q <= bus.addr[0];
      if (wr_act) wdata <= bus.data_in;
      if (ctrl_wr_tr) begin
        rxie <= wdata[0];
        txie <= wdata[1];
      end
      txovf   <= (txovf & ~stat_rd_tr) | (data_wr_tr & tx_full);
      ovr     <= (ovr & ~stat_rd_tr) | (rx_v2 & rx_stop & rx_full);
      ferr    <= (ferr & ~stat_rd_tr) | (rx_v2 & ~rx_stop);
      int_req <= (rxie & ~rx_empty) | (txie & tx_empty);
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (tx_push) tx_mem[tx_wp[FIFO_AW-1:0]] <= wdata;
    if (rx_push) rx_mem[rx_wp[FIFO_AW-1:0]] <= rx_sh;
  end

  // FIFO pointers; flush wins over a same-cycle push or pop
  always_ff @(posedge cpu_clk or negedge n_RST) begin
    if (!n_RST) begin
      tx_wp <= '0; tx_rp <= '0; rx_wp <= '0; rx_rp <= '0;
    end else begin
      if (tx_flush) begin
        tx_wp <= '0; tx_rp <= '0;
      end else begin
        if (tx_push) tx_wp <= tx_wp + PW'(1);
        if (tx_pop)  tx_rp <= tx_rp + PW'(1);
      end
      if (rx_flush) begin
        rx_wp <= '0; rx_rp <= '0;
      end else begin
        if (rx_push) rx_wp <= rx_wp + PW'(1);
        if (rx_pop)  rx_rp <= rx_rp + PW'(1);
      end
    end
  end

  // Transmitter: back-to-back frames reload straight from STOP
  always_ff @(posedge cpu_clk or negedge n_RST) begin
    if (!n_RST) begin
      tx_state <= S_IDLE; tx_cnt <= '0; tx_bit <= 3'd0; tx_sh <= 8'h00; txd <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: if (tx_ready) begin
          tx_state <= S_START; tx_cnt <= '0; tx_sh <= tx_head; txd <= 1'b0;
        end
        S_START: if (tx_end) begin
          tx_state <= S_DATA; tx_cnt <= '0; tx_bit <= 3'd0;
          txd <= tx_sh[0]; tx_sh <= tx_sh >> 1;
        end else tx_cnt <= tx_cnt + CW'(1);
        S_DATA: if (tx_end) begin
          tx_cnt <= '0;
          if (tx_bit == 3'd7) begin
            tx_state <= S_STOP; txd <= 1'b1;
          end else begin
            tx_bit <= tx_bit + 3'd1; txd <= tx_sh[0]; tx_sh <= tx_sh >> 1;
          end
        end else tx_cnt <= tx_cnt + CW'(1);
        default: if (tx_end) begin
          tx_cnt <= '0;
          if (tx_ready) begin
            tx_state <= S_START; tx_sh <= tx_head; txd <= 1'b0;
          end else tx_state <= S_IDLE;
        end else tx_cnt <= tx_cnt + CW'(1);
      endcase
    end
  end

  // Receiver: synchronise, find start, mid-bit sampling, two-stage hand-off
  always_ff @(posedge cpu_clk or negedge n_RST) begin
    if (!n_RST) begin
      rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_prev <= 1'b1;
      rx_state <= S_IDLE; rx_cnt <= '0; rx_bit <= 3'd0; rx_sh <= 8'h00;
      rx_v1 <= 1'b0; rx_v2 <= 1'b0; rx_stop <= 1'b0;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      rx_v1   <= 1'b0;
      rx_v2   <= rx_v1;
      case (rx_state)
        S_IDLE: if (rx_prev & ~rx_s2) begin
          rx_state <= S_START; rx_cnt <= '0;
        end
        S_START: if (rx_cnt == HALF_END) begin
          rx_cnt <= '0; rx_bit <= 3'd0;
          rx_state <= rx_s2 ? S_IDLE : S_DATA;
        end else rx_cnt <= rx_cnt + CW'(1);
        S_DATA: if (rx_cnt == BIT_END) begin
          rx_cnt <= '0;
          rx_sh  <= {rx_s2, rx_sh[7:1]};
          if (rx_bit == 3'd7) rx_state <= S_STOP;
          else rx_bit <= rx_bit + 3'd1;
        end else rx_cnt <= rx_cnt + CW'(1);
        default: if (rx_cnt == BIT_END) begin
          rx_cnt <= '0; rx_v1 <= 1'b1; rx_stop <= rx_s2; rx_state <= S_IDLE;
        end else rx_cnt <= rx_cnt + CW'(1);
      endcase
    end
  end
endmodule

// File: tb/tb_z80_fifo_uart.sv
// Directed bench for z80_fifo_uart: register access, TX framing, loopback,
// RX overflow/framing/glitch, interrupts and mid-frame reset.
module tb_z80_fifo_uart;
  localparam int unsigned B  = 8;
  localparam int unsigned AW = 2;
  localparam logic [7:0] DATA_A = 8'h84;
  localparam logic [7:0] STAT_A = 8'h85;

  logic cpu_clk = 1'b0;
  logic n_RST   = 1'b0;
  logic txd, int_req, rxd;
  logic loop    = 1'b0;
  logic rx_drv  = 1'b1;
  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;

  assign rxd = loop ? txd : rx_drv;

  z80_fifo_uart_if bus ();

  z80_fifo_uart #(.BASE_ADDR(DATA_A), .FIFO_AW(AW), .BAUD_DIV(B)) dut (
    .n_RST   (n_RST),
    .cpu_clk (cpu_clk),
    .bus     (bus),
    .int_req (int_req),
    .txd     (txd),
    .rxd     (rxd)
  );

  always #5 cpu_clk = ~cpu_clk;
  always @(posedge cpu_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge cpu_clk);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge cpu_clk);
  endtask

  task automatic io_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge cpu_clk);
    bus.addr = a; bus.iorq = 1'b1; bus.wr = 1'b1; bus.data_in = d;
    @(negedge cpu_clk);
    bus.iorq = 1'b0; bus.wr = 1'b0;
  endtask

  task automatic io_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge cpu_clk);
    bus.addr = a; bus.iorq = 1'b1; bus.rd = 1'b1;
    #1 d = bus.data_out;
    @(negedge cpu_clk);
    bus.iorq = 1'b0; bus.rd = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx_drv = 1'b0;
    repeat (B) @(negedge cpu_clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (B) @(negedge cpu_clk);
    end
    rx_drv = stop;
    repeat (B) @(negedge cpu_clk);
    rx_drv = 1'b1;
    repeat (2 * B) @(negedge cpu_clk);
  endtask

  initial begin
    logic [7:0] d;
    logic [9:0] fr;
    logic [7:0] lb [6];
    logic [7:0] ov [4];
    int c, s0;

    bus.addr = 8'h00; bus.iorq = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0; bus.data_in = 8'h00;
    idle(3);
    check("rst_txd", 8'(txd), 8'h01);
    check("rst_int", 8'(int_req), 8'h00);
    check("rst_dout", bus.data_out, 8'h00);
    n_RST = 1'b1;
    idle(2);

    // Address decode and idle read bus
    @(negedge cpu_clk);
    bus.addr = STAT_A; bus.iorq = 1'b1;
    #1 check("sel_hit", 8'(bus.sel), 8'h01);
    check("dout_no_rd", bus.data_out, 8'h00);
    bus.addr = 8'h86;
    #1 check("sel_miss", 8'(bus.sel), 8'h00);
    bus.iorq = 1'b0;
    io_read(STAT_A, d); check("stat_reset", d, 8'h12);

    // Single A5 frame: start bit two cycles after the trailing edge
    fr = {1'b1, 8'hA5, 1'b0};
    io_write(DATA_A, 8'hA5);
    c = cyc;
    wait_cyc(c + 1); check("tx_lat", 8'(txd), 8'h01);
    for (int i = 0; i < 10; i++) begin
      wait_cyc(c + 2 + i * B);         check("tx_bit_first", 8'(txd), 8'(fr[i]));
      wait_cyc(c + 2 + i * B + B - 1); check("tx_bit_last", 8'(txd), 8'(fr[i]));
    end
    idle(2 * B);
    io_read(STAT_A, d); check("stat_tx_done", d, 8'h12);

    // Loopback: shifter takes byte 0, FIFO fills with 1..4, byte 5 dropped
    lb[0] = 8'h11; lb[1] = 8'h22; lb[2] = 8'h33; lb[3] = 8'h44; lb[4] = 8'h55; lb[5] = 8'h66;
    loop = 1'b1;
    idle(2);
    io_write(DATA_A, lb[0]);
    s0 = cyc + 2;
    for (int k = 1; k < 6; k++) io_write(DATA_A, lb[k]);
    io_read(STAT_A, d); check("stat_txovf", d, 8'h20);
    io_read(STAT_A, d); check("stat_txovf_clr", d, 8'h00);
    for (int k = 1; k < 5; k++) begin
      wait_cyc(s0 + 80 * k - 1); check("gap_stop", 8'(txd), 8'h01);
      wait_cyc(s0 + 80 * k);     check("gap_start", 8'(txd), 8'h00);
      wait_cyc(s0 + 80 * k + 20);
      io_read(DATA_A, d); check("lb_data", d, lb[k-1]);
    end
    wait_cyc(s0 + 420);
    io_read(DATA_A, d); check("lb_data_last", d, lb[4]);
    io_read(DATA_A, d); check("rx_empty_read", d, 8'h00);
    io_read(STAT_A, d); check("lb_final", d, 8'h12);

    // RX overflow: fifth frame into a full FIFO is discarded
    loop = 1'b0;
    idle(4);
    ov[0] = 8'hA1; ov[1] = 8'hB2; ov[2] = 8'hC3; ov[3] = 8'hD4;
    for (int k = 0; k < 4; k++) send_frame(ov[k], 1'b1);
    send_frame(8'hE5, 1'b1);
    check("int_disabled", 8'(int_req), 8'h00);
    io_read(STAT_A, d); check("stat_ovr", d, 8'h17);
    io_read(STAT_A, d); check("stat_ovr_clr", d, 8'h13);
    for (int k = 0; k < 4; k++) begin
      io_read(DATA_A, d); check("ovr_data", d, ov[k]);
    end
    io_read(STAT_A, d); check("stat_ovr_empty", d, 8'h12);

    // Framing error, then a quarter-bit glitch
    send_frame(8'h5A, 1'b0);
    io_read(STAT_A, d); check("stat_ferr", d, 8'h1A);
    io_read(STAT_A, d); check("stat_ferr_clr", d, 8'h12);
    rx_drv = 1'b0;
    idle(B / 4);
    rx_drv = 1'b1;
    idle(3 * B);
    io_read(STAT_A, d); check("glitch", d, 8'h12);

    // Interrupts
    io_write(STAT_A, 8'h01);
    idle(2); check("int_rx_idle", 8'(int_req), 8'h00);
    send_frame(8'h3C, 1'b1);
    check("int_rx", 8'(int_req), 8'h01);
    io_read(DATA_A, d); check("int_rx_data", d, 8'h3C);
    idle(2); check("int_rx_clr", 8'(int_req), 8'h00);
    io_write(STAT_A, 8'h02);
    idle(2); check("int_tx", 8'(int_req), 8'h01);

    // Reset in the middle of a frame with another byte queued
    io_write(DATA_A, 8'h00);
    c = cyc;
    io_write(DATA_A, 8'hFF);
    wait_cyc(c + 2 + 20); check("tx_mid", 8'(txd), 8'h00);
    n_RST = 1'b0;
    #1 check("rst_txd_async", 8'(txd), 8'h01);
    idle(2);
    n_RST = 1'b1;
    idle(1);
    io_read(STAT_A, d); check("rst_stat", d, 8'h12);
    idle(2); check("rst_int_clr", 8'(int_req), 8'h00);
    idle(3 * B); check("rst_no_tx", 8'(txd), 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
